bch_63_56_decoder: RTL and testbench

Receive-side counterpart of the BCH(63,56) encode/error-injection path. It accepts one 63-bit received word Rn and serially computes the syndrome S1 = r(α) over GF(2^6) together with the overall parity. It then corrects a single error or flags an uncorrectable word, and returns the 56 data bits through a ready/valid output. It sits between the channel model (error injector driven by ne/l1/l2/l3) and the TorF checker.

---
 rtl/bch_63_56_pkg.sv | 28 ++
 rtl/bch_63_56_syndrome.sv | 31 +++
 rtl/bch_63_56_decoder.sv | 137 +++++++++++++
 tb/tb_bch_63_56_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_63_56_pkg.sv
// Shared constants, FSM state type and GF(2^6) helper for the BCH(63,56) decoder.
package bch_63_56_pkg;

  localparam int N = 63;
  localparam int K = 56;
  localparam logic [6:0] PRIM_POLY = 7'b1000011;
  localparam logic [7:0] GEN_POLY  = 8'b11000101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYND   = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Multiply a GF(64) element by alpha, reducing modulo x^6+x+1
  function automatic logic [5:0] gf64_mul_alpha(input logic [5:0] a);
    logic [5:0] r;
    r = {a[4:0], 1'b0};
    if (a[5]) begin
      r = r ^ PRIM_POLY[5:0];
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_63_56_syndrome.sv
// Serial Horner accumulator for S1 = r(alpha) and overall parity, one bit per cycle MSB first.
module bch_63_56_syndrome
  import bch_63_56_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [5:0] syn,
  output logic       par
);

  // Syndrome and parity accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syn <= 6'd0;
      par <= 1'b0;
    end else if (clr) begin
      syn <= 6'd0;
      par <= 1'b0;
    end else if (en) begin
      syn <= gf64_mul_alpha(syn) ^ {5'd0, bit_in};
      par <= par ^ bit_in;
    end else begin
      syn <= syn;
      par <= par;
    end
  end

endmodule

// File: rtl/bch_63_56_decoder.sv
// BCH(63,56) SEC-DED decoder: serial syndrome, fixed-length Chien-style search, registered result.
module bch_63_56_decoder
  import bch_63_56_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  rn,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  data,
  output logic          corrected,
  output logic          uncorrectable,
  output logic [5:0]    err_loc
);

  state_t       state;
  logic [N-1:0] r_buf;
  logic [5:0]   cnt;
  logic [5:0]   t;
  logic [5:0]   j;
  logic [5:0]   jpos;
  logic         found;
  logic [5:0]   syn;
  logic         par;
  logic         syn_clr;
  logic         syn_en;
  logic         syn_bit;
  logic         single;
  logic         no_err;
  logic [K-1:0] flip;
  logic [K-1:0] fix_data;

  assign syn_clr = (state == IDLE);
  assign syn_en  = (state == SYND);
  assign syn_bit = r_buf[cnt];
  assign single  = (syn != 6'd0) && par;
  assign no_err  = (syn == 6'd0) && !par;

  bch_63_56_syndrome u_syndrome (
    .clk    (clk),
    .rst    (rst),
    .clr    (syn_clr),
    .en     (syn_en),
    .bit_in (syn_bit),
    .syn    (syn),
    .par    (par)
  );

  // Corrected data word; parity-position errors (jpos < 7) leave data untouched
  always_comb begin
    flip     = {K{1'b0}};
    fix_data = r_buf[N-1:7];
    if (jpos >= 6'd7) begin
      flip = {{(K-1){1'b0}}, 1'b1} << (jpos - 6'd7);
    end else begin
      flip = {K{1'b0}};
    end
    if (single && found) begin
      fix_data = r_buf[N-1:7] ^ flip;
    end else begin
      fix_data = r_buf[N-1:7];
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      data          <= {K{1'b0}};
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      err_loc       <= 6'd0;
      r_buf         <= {N{1'b0}};
      cnt           <= 6'd0;
      t             <= 6'd0;
      j             <= 6'd0;
      jpos          <= 6'd0;
      found         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            r_buf    <= rn;
            cnt      <= 6'd62;
            jpos     <= 6'd0;
            found    <= 1'b0;
            in_ready <= 1'b0;
            state    <= SYND;
          end
        end
        SYND: begin
          if (cnt == 6'd0) begin
            t     <= 6'd1;
            j     <= 6'd0;
            state <= SEARCH;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        SEARCH: begin
          // Only the first match counts; the scan always runs all 63 steps
          if (!found && single && (t == syn)) begin
            found <= 1'b1;
            jpos  <= j;
          end
          t <= gf64_mul_alpha(t);
          j <= j + 6'd1;
          if (j == 6'd62) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid     <= 1'b1;
            data          <= fix_data;
            corrected     <= single && found;
            uncorrectable <= !(single && found) && !no_err;
            err_loc       <= (single && found) ? (6'd62 - jpos) : 6'd0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_63_56_decoder.sv
// Scoreboard bench for bch_63_56_decoder: directed and random words checked against a GF(64) reference model.
module tb_bch_63_56_decoder;

  typedef struct {
    logic [55:0] d;
    logic        corr;
    logic        unc;
    logic [5:0]  loc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [62:0] rn;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] data;
  logic        corrected;
  logic        uncorrectable;
  logic [5:0]  err_loc;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic hold = 1'b0;
  exp_t exp_q[$];
  int   lat_q[$];

  bch_63_56_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .rn            (rn),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data          (data),
    .corrected     (corrected),
    .uncorrectable (uncorrectable),
    .err_loc       (err_loc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Systematic encoder: parity = d*x^7 mod g(x), g = x^7+x^6+x^2+1
  function automatic logic [62:0] encode(input logic [55:0] d);
    logic [62:0] rem;
    logic [62:0] g;
    g   = 63'h0C5;
    rem = {d, 7'd0};
    for (int i = 62; i >= 7; i--) begin
      if (rem[i]) rem = rem ^ (g << (i - 7));
    end
    return {d, rem[6:0]};
  endfunction

  // Reference decoder: S = sum of alpha^i over set bits, P = popcount parity
  function automatic exp_t model(input logic [62:0] w);
    exp_t e;
    int   av;
    int   s;
    int   p;
    int   jf;
    s = 0; p = 0; av = 1; jf = -1;
    for (int i = 0; i < 63; i++) begin
      if (w[i]) begin
        s = s ^ av;
        p = p ^ 1;
      end
      av = av * 2;
      if (av >= 64) av = av ^ 67;
    end
    e.d = w[62:7]; e.corr = 1'b0; e.unc = 1'b0; e.loc = 6'd0;
    if (s != 0 && p == 1) begin
      av = 1;
      for (int k = 0; k < 63; k++) begin
        if (jf < 0 && av == s) jf = k;
        av = av * 2;
        if (av >= 64) av = av ^ 67;
      end
      if (jf >= 7) e.d[jf-7] = ~e.d[jf-7];
      e.corr = 1'b1;
      e.loc  = 6'(62 - jf);
    end else if (s != 0 || p == 1) begin
      e.unc = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [55:0] d, input logic c, input logic u, input logic [5:0] l);
    exp_t e;
    e.d = d; e.corr = c; e.unc = u; e.loc = l;
    return e;
  endfunction

  task automatic send_word(input logic [62:0] w, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1;
    rn = w;
    exp_q.push_back(e);
    lat_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    // Junk on rn with in_valid high while busy must be ignored
    for (int k = 0; k < 40; k++) begin
      rn = {$urandom(), $urandom()};
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Sink back-pressure
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency, stability under stall and scoreboard comparison
  initial begin
    logic        prev_valid;
    logic        stall_prev;
    logic [63:0] held;
    exp_t        e;
    int          a;
    prev_valid = 1'b0;
    stall_prev = 1'b0;
    held = 64'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (lat_q.size() == 0) begin
            chk("unexpected_out_valid", 64'd1, 64'd0);
          end else begin
            a = lat_q.pop_front();
            chk("latency", 64'(cyc - a), 64'd127);
          end
        end
        if (out_valid && stall_prev)
          chk("stable", {data, corrected, uncorrectable, err_loc}, held);
        if (out_valid) begin
          chk("in_ready_busy", 64'(in_ready), 64'd0);
          chk("flags_exclusive", 64'(corrected & uncorrectable), 64'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("data", 64'(data), 64'(e.d));
            chk("corrected", 64'(corrected), 64'(e.corr));
            chk("uncorrectable", 64'(uncorrectable), 64'(e.unc));
            chk("err_loc", 64'(err_loc), 64'(e.loc));
          end
        end
        prev_valid = out_valid;
        stall_prev = out_valid && !out_ready;
        held = {data, corrected, uncorrectable, err_loc};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [62:0] cw;
    logic [62:0] w;
    logic [63:0] tmp;
    logic [55:0] dd;
    int          ne;
    int          p1, p2, p3;

    rst = 1'b1; in_valid = 1'b0; rn = 63'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {7'd0, out_valid, data[55:0] != 56'd0, corrected, uncorrectable, err_loc != 6'd0, in_ready, 50'd0}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    send_word(63'd0, mk(56'd0, 1'b0, 1'b0, 6'd0));
    send_word(63'h4000_0000_0000_0000, mk(56'd0, 1'b1, 1'b0, 6'd0));
    send_word(63'd1 << 7, mk(56'd0, 1'b1, 1'b0, 6'd55));
    send_word(63'd1, mk(56'd0, 1'b1, 1'b0, 6'd62));

    dd = 56'hDD_DDDD_DDDD_DDDD;
    cw = encode(dd);
    send_word(cw, mk(dd, 1'b0, 1'b0, 6'd0));
    for (int l = 0; l < 63; l++) begin
      w = cw ^ (63'd1 << (62 - l));
      send_word(w, mk(dd, 1'b1, 1'b0, 6'(l)));
    end
    w = cw ^ (63'd1 << 62) ^ (63'd1 << 61);
    send_word(w, mk(w[62:7], 1'b0, 1'b1, 6'd0));
    w = cw ^ (63'd1 << 62) ^ (63'd1 << 61) ^ (63'd1 << 60);
    send_word(w, model(w));

    for (int k = 0; k < 20; k++) begin
      tmp = {$urandom(), $urandom()};
      if (k < 15) begin
        w  = encode(tmp[55:0]);
        ne = $urandom_range(0, 3);
        p1 = $urandom_range(0, 62);
        p2 = (p1 + $urandom_range(1, 20)) % 63;
        p3 = (p2 + $urandom_range(1, 20)) % 63;
        if (p3 == p1) p3 = (p3 + 1) % 63;
        if (ne >= 1) w = w ^ (63'd1 << p1);
        if (ne >= 2) w = w ^ (63'd1 << p2);
        if (ne >= 3) w = w ^ (63'd1 << p3);
      end else begin
        w = {tmp[62:0]};
      end
      send_word(w, model(w));
    end
    drain();

    hold = 1'b1;
    w = cw ^ (63'd1 << 30);
    send_word(w, mk(dd, 1'b1, 1'b0, 6'd32));
    for (int n = 0; n < 300 && !out_valid; n++) @(negedge clk);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    repeat (20) @(negedge clk);
    hold = 1'b0;
    drain();

    send_word(cw ^ (63'd1 << 50), mk(dd, 1'b1, 1'b0, 6'd12));
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", {out_valid, in_ready, corrected, uncorrectable, err_loc, data}, 64'd0);
    exp_q.delete();
    lat_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    w = cw ^ (63'd1 << 20);
    send_word(w, mk(dd, 1'b1, 1'b0, 6'd42));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
